// File: rtl/mdu_pkg.sv
// Shared op codes and helpers for the multiply/divide unit.
// Also used by the decoder to flag MDU-class instructions.
package mdu_pkg;

  localparam int MDU_OP_W = 4;

  localparam logic [MDU_OP_W-1:0] MDU_NONE  = 4'd0;
  localparam logic [MDU_OP_W-1:0] MDU_MULT  = 4'd1;
  localparam logic [MDU_OP_W-1:0] MDU_MULTU = 4'd2;
  localparam logic [MDU_OP_W-1:0] MDU_DIV   = 4'd3;
  localparam logic [MDU_OP_W-1:0] MDU_DIVU  = 4'd4;
  localparam logic [MDU_OP_W-1:0] MDU_MFHI  = 4'd5;
  localparam logic [MDU_OP_W-1:0] MDU_MFLO  = 4'd6;
  localparam logic [MDU_OP_W-1:0] MDU_MTHI  = 4'd7;
  localparam logic [MDU_OP_W-1:0] MDU_MTLO  = 4'd8;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        wr;
  } mdu_res_t;

  function automatic logic is_mul_op(
    input logic [MDU_OP_W-1:0] op
  );
    return (op == MDU_MULT) || (op == MDU_MULTU);
  endfunction

  function automatic logic is_div_op(
    input logic [MDU_OP_W-1:0] op
  );
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic is_start_op(
    input logic [MDU_OP_W-1:0] op
  );
    return is_mul_op(op) || is_div_op(op);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational 64b product and quotient/remainder.
// Signed ops work on magnitudes, then fix up the signs.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [MDU_OP_W-1:0] op_i,
  input  logic [31:0]         a_i,
  input  logic [31:0]         b_i,
  output mdu_res_t            res_o
);

  logic        sgn;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] b_safe;
  logic [63:0] p_mag;
  logic [63:0] prod;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quo;
  logic [31:0] rem;

  assign sgn   = (op_i == MDU_MULT) || (op_i == MDU_DIV);
  assign a_neg = sgn & a_i[31];
  assign b_neg = sgn & b_i[31];
  assign a_mag = a_neg ? (32'd0 - a_i) : a_i;
  assign b_mag = b_neg ? (32'd0 - b_i) : b_i;

  assign p_mag = {32'd0, a_mag} * {32'd0, b_mag};
  assign prod  = (a_neg ^ b_neg) ? (64'd0 - p_mag) : p_mag;

  // Zero divisor is masked so the divider never yields X;
  // the result is discarded through wr anyway.
  assign b_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
  assign q_mag  = a_mag / b_safe;
  assign r_mag  = a_mag % b_safe;
  assign quo    = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
  assign rem    = a_neg ? (32'd0 - r_mag) : r_mag;

  always_comb begin
    res_o = '0;
    unique case (1'b1)
      is_mul_op(op_i): begin
        res_o.hi = prod[63:32];
        res_o.lo = prod[31:0];
        res_o.wr = 1'b1;
      end
      is_div_op(op_i): begin
        res_o.hi = rem;
        res_o.lo = quo;
        res_o.wr = (b_i != 32'd0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu.sv
// E-stage multiply/divide unit: HI/LO, pending result, busy counter.
// Results sit in the pend registers until the counter expires.
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [MDU_OP_W-1:0] E_MDU_op,
  input  logic [31:0]         E_rs_data,
  input  logic [31:0]         E_rt_data,
  output logic                E_MDU_start,
  output logic                E_MDU_busy,
  output logic [31:0]         E_MDU_out
);

  localparam int MAXC  = (MULT_CYCLES > DIV_CYCLES) ?
                         MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W = $clog2(MAXC) + 1;

  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [31:0]      hi_pend_q, hi_pend_d;
  logic [31:0]      lo_pend_q, lo_pend_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  mdu_res_t         res;
  logic             idle;

  mdu_arith u_arith (
    .op_i  (E_MDU_op),
    .a_i   (E_rs_data),
    .b_i   (E_rt_data),
    .res_o (res)
  );

  assign E_MDU_busy  = (cnt_q != '0);
  assign idle        = ~E_MDU_busy;
  assign E_MDU_start = is_start_op(E_MDU_op) & idle;

  always_comb begin
    E_MDU_out = 32'd0;
    if (E_MDU_op == MDU_MFHI) E_MDU_out = hi_q;
    if (E_MDU_op == MDU_MFLO) E_MDU_out = lo_q;
  end

  always_comb begin
    hi_d      = hi_q;
    lo_d      = lo_q;
    hi_pend_d = hi_pend_q;
    lo_pend_d = lo_pend_q;
    cnt_d     = cnt_q;
    unique case (1'b1)
      E_MDU_start: begin
        // A zero-divisor divide re-commits the current HI/LO,
        // which cannot change while busy.
        hi_pend_d = res.wr ? res.hi : hi_q;
        lo_pend_d = res.wr ? res.lo : lo_q;
        cnt_d     = is_mul_op(E_MDU_op) ?
                    CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
      end
      E_MDU_busy: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          hi_d = hi_pend_q;
          lo_d = lo_pend_q;
        end
      end
      (idle && E_MDU_op == MDU_MTHI): hi_d = E_rs_data;
      (idle && E_MDU_op == MDU_MTLO): lo_d = E_rs_data;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q      <= '0;
      lo_q      <= '0;
      hi_pend_q <= '0;
      lo_pend_q <= '0;
      cnt_q     <= '0;
    end else begin
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      hi_pend_q <= hi_pend_d;
      lo_pend_q <= lo_pend_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mdu.sv
// Directed bench for mdu: mult/div results, busy timing,
// divide by zero, async reset mid-op and back-to-back starts.
module tb_mdu;
  import mdu_pkg::*;

  logic                clk = 1'b0;
  logic                reset;
  logic [MDU_OP_W-1:0] op;
  logic [31:0]         rs;
  logic [31:0]         rt;
  logic                start;
  logic                busy;
  logic [31:0]         out;
  int                  total = 0;
  int                  bad = 0;

  always #5 clk = ~clk;

  mdu #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .E_MDU_op    (op),
    .E_rs_data   (rs),
    .E_rt_data   (rt),
    .E_MDU_start (start),
    .E_MDU_busy  (busy),
    .E_MDU_out   (out)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(
    input logic [MDU_OP_W-1:0] o,
    input logic [31:0]         a,
    input logic [31:0]         b
  );
    @(negedge clk);
    op = o;
    rs = a;
    rt = b;
    #1;
  endtask

  task automatic rd(
    input string       tag,
    input logic [31:0] eh,
    input logic [31:0] el
  );
    drive(MDU_MFHI, 32'd0, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_hi"}, out, eh);
    drive(MDU_MFLO, 32'd0, 32'd0);
    chk({tag, "_lo"}, out, el);
  endtask

  task automatic run(
    input string               tag,
    input logic [MDU_OP_W-1:0] o,
    input logic [31:0]         a,
    input logic [31:0]         b,
    input int                  n
  );
    drive(o, a, b);
    chk({tag, "_start"}, {31'd0, start}, 32'd1);
    chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
    for (int k = 1; k <= n; k++) begin
      drive(MDU_NONE, 32'd0, 32'd0);
      chk({tag, "_bsy"}, {31'd0, busy}, 32'd1);
    end
  endtask

  initial begin
    reset = 1'b1;
    op    = MDU_MULT;
    rs    = 32'h1234;
    rt    = 32'h5678;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_start", {31'd0, start}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    op    = MDU_NONE;
    rd("rst", 32'd0, 32'd0);

    drive(MDU_MTHI, 32'h0000AAAA, 32'd0);
    drive(MDU_MTLO, 32'h00005555, 32'd0);
    rd("mt", 32'h0000AAAA, 32'h00005555);

    drive(MDU_MULT, 32'hFFFFFFFE, 32'd3);
    chk("mult_start", {31'd0, start}, 32'd1);
    for (int k = 1; k <= 5; k++) begin
      if (k == 3) begin
        drive(MDU_MFHI, 32'd0, 32'd0);
        chk("mult_oldhi", out, 32'h0000AAAA);
      end else begin
        drive(MDU_NONE, 32'd0, 32'd0);
      end
      chk("mult_bsy", {31'd0, busy}, 32'd1);
    end
    rd("mult", 32'hFFFFFFFF, 32'hFFFFFFFA);
    drive(MDU_NONE, 32'd0, 32'd0);
    chk("none_out", out, 32'd0);

    run("multu", MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5);
    rd("multu", 32'hFFFFFFFE, 32'h00000001);

    run("div", MDU_DIV, 32'hFFFFFFF9, 32'd2, 10);
    rd("div", 32'hFFFFFFFF, 32'hFFFFFFFD);

    run("divmin", MDU_DIV, 32'h80000000, 32'hFFFFFFFF, 10);
    rd("divmin", 32'd0, 32'h80000000);

    run("divu", MDU_DIVU, 32'hFFFFFFF9, 32'd2, 10);
    rd("divu", 32'd1, 32'h7FFFFFFC);

    drive(MDU_MTHI, 32'h11, 32'd0);
    drive(MDU_MTLO, 32'h22, 32'd0);
    run("div0", MDU_DIVU, 32'd5, 32'd0, 10);
    rd("div0", 32'h11, 32'h22);

    run("rdiv", MDU_DIV, 32'd100, 32'd7, 2);
    @(negedge clk);
    reset = 1'b1;
    op    = MDU_NONE;
    #1;
    chk("rmid_busy", {31'd0, busy}, 32'd0);
    drive(MDU_NONE, 32'd0, 32'd0);
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      drive(MDU_NONE, 32'd0, 32'd0);
      chk("rmid_idle", {31'd0, busy}, 32'd0);
    end
    rd("rmid", 32'd0, 32'd0);

    drive(MDU_MULT, 32'd3, 32'd4);
    chk("b2b_start0", {31'd0, start}, 32'd1);
    for (int k = 1; k <= 5; k++) begin
      drive(MDU_MULT, 32'd5, 32'd6);
      chk("b2b_bsy", {31'd0, busy}, 32'd1);
      chk("b2b_nostart", {31'd0, start}, 32'd0);
    end
    drive(MDU_MULT, 32'd5, 32'd6);
    chk("b2b_idle", {31'd0, busy}, 32'd0);
    chk("b2b_start1", {31'd0, start}, 32'd1);
    for (int k = 1; k <= 5; k++) begin
      drive(MDU_NONE, 32'd0, 32'd0);
      chk("b2b_bsy2", {31'd0, busy}, 32'd1);
    end
    rd("b2b", 32'd0, 32'd30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
